genius_ctrl: RTL and testbench

Game sequencer for the Genius (Simon) memory game. It drives the sequence-ROM address and reads back the one-hot colour for each step. For each level it plays steps 0..level on the LEDs, then collects and checks the player's button presses. It sits between the sequence ROM, the debounced button inputs and the LED/status outputs of the top level.

---
 rtl/genius_pkg.sv | 24 ++
 rtl/genius_ctrl_if.sv | 25 ++
 rtl/genius_timer.sv | 31 +++
 rtl/genius_ctrl.sv | 156 +++++++++++++++
 tb/tb_genius_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game sequencer.
package genius_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShowOn,
    StShowOff,
    StWaitIn,
    StEcho,
    StShowOffGap,
    StWin,
    StLose
  } state_e;

  localparam logic [3:0] LED_OFF  = 4'b0000;
  localparam logic [3:0] LED_ALL  = 4'b1111;
  localparam logic [3:0] MAX_STEP = 4'd15;

  // A press is the rising edge of "any button down".
  function automatic logic is_press(logic [3:0] prev, logic [3:0] cur);
    return (prev == 4'b0000) && (cur != 4'b0000);
  endfunction

endpackage

// File: rtl/genius_ctrl_if.sv
// Game-side signals of the sequencer: ROM bus, buttons, start and display outputs.
interface genius_ctrl_if;
  import genius_pkg::*;

  logic       start;
  logic [3:0] botao;
  logic [3:0] seq_led;
  logic [3:0] seq_addr;
  logic [3:0] leds;
  logic [4:0] nivel;
  logic       vez_jogador;
  logic       ganhou;
  logic       perdeu;

  modport master (
    output start, botao, seq_led,
    input  seq_addr, leds, nivel, vez_jogador, ganhou, perdeu
  );

  modport slave (
    input  start, botao, seq_led,
    output seq_addr, leds, nivel, vez_jogador, ganhou, perdeu
  );

endinterface

// File: rtl/genius_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
module genius_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  input  logic [Width-1:0] cmp_val,
  output logic             done
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == cmp_val);

endmodule

// File: rtl/genius_ctrl.sv
// Genius game sequencer: replays the ROM sequence per level, then checks the player's presses.
module genius_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned T_ON      = 50,
  parameter int unsigned T_OFF     = 25,
  parameter int unsigned T_TIMEOUT = 500,
  parameter int unsigned LAST_LVL  = 15
) (
  input logic         clk,
  input logic         rst_n,
  genius_ctrl_if.slave bus
);

  localparam int unsigned TMax = (T_ON > T_OFF) ? ((T_ON > T_TIMEOUT) ? T_ON : T_TIMEOUT)
                                                : ((T_OFF > T_TIMEOUT) ? T_OFF : T_TIMEOUT);
  localparam int unsigned TW   = $clog2(TMax) + 1;
  localparam logic [3:0] LastLvl = (LAST_LVL > int'(MAX_STEP)) ? MAX_STEP : 4'(LAST_LVL);

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] echo_q, echo_d;
  logic [3:0] prev_botao_q;

  logic          press;
  logic          timer_clr;
  logic          timer_done;
  logic [TW-1:0] timer_cmp;

  assign press = is_press(prev_botao_q, bus.botao);

  // One timer serves every timed state; the terminal value follows the state.
  always_comb begin
    timer_cmp = '0;
    unique case (state_q)
      StShowOn, StEcho:          timer_cmp = TW'(T_ON - 1);
      StShowOff, StShowOffGap:   timer_cmp = TW'(T_OFF - 1);
      StWaitIn:                  timer_cmp = TW'(T_TIMEOUT - 1);
      default:                   timer_cmp = '0;
    endcase
  end

  assign timer_clr = (state_d != state_q) || (state_q == StIdle) ||
                     (state_q == StWin) || (state_q == StLose);

  genius_timer #(
    .Width (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (1'b1),
    .cmp_val  (timer_cmp),
    .done     (timer_done)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    echo_d  = echo_q;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (bus.start) begin
          level_d = '0;
          idx_d   = '0;
          state_d = StShowOn;
        end
      end
      StShowOn: begin
        if (timer_done) state_d = StShowOff;
      end
      StShowOff: begin
        if (timer_done) begin
          if (idx_q == level_q) begin
            idx_d   = '0;
            state_d = StWaitIn;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StShowOn;
          end
        end
      end
      StWaitIn: begin
        // A press in the timeout cycle still counts.
        if (press) begin
          if (bus.botao == bus.seq_led) begin
            echo_d  = bus.botao;
            state_d = StEcho;
          end else begin
            state_d = StLose;
          end
        end else if (timer_done) begin
          state_d = StLose;
        end
      end
      StEcho: begin
        if (timer_done) begin
          if (idx_q != level_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = StWaitIn;
          end else if (level_q == LastLvl) begin
            state_d = StWin;
          end else begin
            level_d = level_q + 4'd1;
            idx_d   = '0;
            state_d = StShowOffGap;
          end
        end
      end
      StShowOffGap: begin
        if (timer_done) begin
          idx_d   = '0;
          state_d = StShowOn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      level_q      <= '0;
      idx_q        <= '0;
      echo_q       <= '0;
      prev_botao_q <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      idx_q        <= idx_d;
      echo_q       <= echo_d;
      prev_botao_q <= bus.botao;
    end
  end

  always_comb begin
    bus.leds = LED_OFF;
    unique case (state_q)
      StShowOn, StLose: bus.leds = bus.seq_led;
      StEcho:           bus.leds = echo_q;
      StWin:            bus.leds = LED_ALL;
      default:          bus.leds = LED_OFF;
    endcase
  end

  assign bus.seq_addr    = idx_q;
  assign bus.nivel       = (state_q == StIdle) ? 5'd0 : ({1'b0, level_q} + 5'd1);
  assign bus.vez_jogador = (state_q == StWaitIn) || (state_q == StEcho);
  assign bus.ganhou      = (state_q == StWin);
  assign bus.perdeu      = (state_q == StLose);

endmodule

// File: tb/tb_genius_ctrl.sv
// Self-checking bench for genius_ctrl against a timing model of the game rules.
module tb_genius_ctrl;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int T_TO  = 20;
  localparam int LAST  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  genius_ctrl_if bus ();
  logic [3:0] rom [16];
  assign bus.seq_led = rom[bus.seq_addr];

  genius_ctrl #(
    .T_ON      (T_ON),
    .T_OFF     (T_OFF),
    .T_TIMEOUT (T_TO),
    .LAST_LVL  (LAST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---- stimulus helpers and model (no checking here) ----
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic press_btn(input logic [3:0] v);
    bus.botao = v;
    tick();
    bus.botao = 4'b0000;
  endtask

  function automatic int show_len(input int lvl);
    return (lvl + 1) * (T_ON + T_OFF);
  endfunction

  // Expected LEDs for cycle c of a replay: each step is T_ON lit then T_OFF dark.
  function automatic logic [3:0] exp_show(input int c);
    int step;
    step = c / (T_ON + T_OFF);
    return ((c % (T_ON + T_OFF)) < T_ON) ? rom[step] : 4'b0000;
  endfunction

  function automatic logic [3:0] rand_onehot();
    logic [3:0] v;
    v = 4'b0001 << $urandom_range(0, 3);
    return v;
  endfunction

  // From the first WAIT_IN cycle of level lvl, answer correctly up to next WAIT_IN.
  task automatic finish_level(input int lvl);
    for (int s = 0; s <= lvl; s++) begin
      press_btn(rom[s]);
      run_cycles(T_ON);
    end
    run_cycles(T_OFF + show_len(lvl + 1));
  endtask

  // ---- tests ----
  task automatic test_reset();
    #1 rst_n = 1'b0;
    bus.start = 1'b0;
    bus.botao = 4'b0000;
    tick();
    n_tests++;
    if ({bus.leds, bus.nivel, bus.vez_jogador, bus.ganhou, bus.perdeu} !== 12'd0)
      $display("FAIL reset_outputs got leds=%b nivel=%0d vez=%b g=%b p=%b, want all 0",
               bus.leds, bus.nivel, bus.vez_jogador, bus.ganhou, bus.perdeu);
    n_tests++;
    if (bus.seq_addr !== 4'd0)
      begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.seq_addr); end
    if ({bus.leds, bus.nivel, bus.vez_jogador, bus.ganhou, bus.perdeu} !== 12'd0) n_fail++;
    rst_n = 1'b1;
    run_cycles(2);
    n_tests++;
    if (bus.nivel !== 5'd0 || bus.leds !== 4'b0000 || bus.vez_jogador !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got nivel=%0d leds=%b vez=%b want 0/0000/0",
               bus.nivel, bus.leds, bus.vez_jogador);
    end
  endtask

  task automatic test_level0_replay();
    start_game();
    for (int c = 0; c < show_len(0); c++) begin
      if (c > 0) tick();
      n_tests++;
      if (bus.leds !== exp_show(c) || bus.vez_jogador !== 1'b0 || bus.nivel !== 5'd1) begin
        n_fail++;
        $display("FAIL level0_replay c=%0d got leds=%b vez=%b nivel=%0d want leds=%b vez=0 nivel=1",
                 c, bus.leds, bus.vez_jogador, bus.nivel, exp_show(c));
      end
    end
    tick();
    n_tests++;
    if (bus.vez_jogador !== 1'b1 || bus.nivel !== 5'd1 || bus.leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL level0_wait got vez=%b nivel=%0d leds=%b want 1/1/0000",
               bus.vez_jogador, bus.nivel, bus.leds);
    end
  endtask

  task automatic test_level1_replay();
    press_btn(rom[0]);
    for (int c = 0; c < T_ON; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (bus.leds !== rom[0] || bus.vez_jogador !== 1'b1) begin
        n_fail++;
        $display("FAIL echo c=%0d got leds=%b vez=%b want leds=%b vez=1",
                 c, bus.leds, bus.vez_jogador, rom[0]);
      end
    end
    for (int c = 0; c < T_OFF; c++) begin
      tick();
      n_tests++;
      if (bus.leds !== 4'b0000 || bus.vez_jogador !== 1'b0 || bus.nivel !== 5'd2) begin
        n_fail++;
        $display("FAIL gap c=%0d got leds=%b vez=%b nivel=%0d want 0000/0/2",
                 c, bus.leds, bus.vez_jogador, bus.nivel);
      end
    end
    for (int c = 0; c < show_len(1); c++) begin
      tick();
      n_tests++;
      if (bus.leds !== exp_show(c) || bus.nivel !== 5'd2) begin
        n_fail++;
        $display("FAIL level1_replay c=%0d got leds=%b nivel=%0d want leds=%b nivel=2",
                 c, bus.leds, bus.nivel, exp_show(c));
      end
    end
    tick();
    n_tests++;
    if (bus.vez_jogador !== 1'b1 || bus.nivel !== 5'd2 || bus.seq_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL level1_wait got vez=%b nivel=%0d addr=%0d want 1/2/0",
               bus.vez_jogador, bus.nivel, bus.seq_addr);
    end
  endtask

  task automatic test_wrong_colour();
    logic [3:0] wrong;
    press_btn(rom[0]);
    run_cycles(T_ON);
    n_tests++;
    if (bus.vez_jogador !== 1'b1 || bus.seq_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL step1_wait got vez=%b addr=%0d want 1/1", bus.vez_jogador, bus.seq_addr);
    end
    do wrong = rand_onehot(); while (wrong == rom[1]);
    press_btn(wrong);
    n_tests++;
    if (bus.perdeu !== 1'b1 || bus.leds !== rom[1] || bus.nivel !== 5'd2 ||
        bus.vez_jogador !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong_colour got p=%b leds=%b nivel=%0d vez=%b want 1/%b/2/0",
               bus.perdeu, bus.leds, bus.nivel, bus.vez_jogador, rom[1]);
    end
    run_cycles(3);
    n_tests++;
    if (bus.perdeu !== 1'b1 || bus.nivel !== 5'd2) begin
      n_fail++;
      $display("FAIL lose_hold got p=%b nivel=%0d want 1/2", bus.perdeu, bus.nivel);
    end
  endtask

  task automatic test_ignored_start();
    start_game();
    n_tests++;
    if (bus.perdeu !== 1'b0 || bus.nivel !== 5'd1 || bus.leds !== rom[0]) begin
      n_fail++;
      $display("FAIL restart got p=%b nivel=%0d leds=%b want 0/1/%b",
               bus.perdeu, bus.nivel, bus.leds, rom[0]);
    end
    for (int c = 1; c < show_len(0); c++) begin
      tick();
      bus.start = (c == 1);
      n_tests++;
      if (bus.leds !== exp_show(c) || bus.nivel !== 5'd1) begin
        n_fail++;
        $display("FAIL start_ignored c=%0d got leds=%b nivel=%0d want leds=%b nivel=1",
                 c, bus.leds, bus.nivel, exp_show(c));
      end
    end
    tick();
    n_tests++;
    if (bus.vez_jogador !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_wait got vez=%b want 1", bus.vez_jogador);
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < T_TO; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (bus.vez_jogador !== 1'b1 || bus.perdeu !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait c=%0d got vez=%b p=%b want 1/0",
                 c, bus.vez_jogador, bus.perdeu);
      end
    end
    tick();
    n_tests++;
    if (bus.perdeu !== 1'b1 || bus.leds !== rom[0] || bus.vez_jogador !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_lose got p=%b leds=%b vez=%b want 1/%b/0",
               bus.perdeu, bus.leds, bus.vez_jogador, rom[0]);
    end
    // Press landing in the final allowed cycle must beat the timeout.
    start_game();
    run_cycles(show_len(0) + T_TO - 1);
    press_btn(rom[0]);
    n_tests++;
    if (bus.perdeu !== 1'b0 || bus.vez_jogador !== 1'b1 || bus.leds !== rom[0]) begin
      n_fail++;
      $display("FAIL press_beats_timeout got p=%b vez=%b leds=%b want 0/1/%b",
               bus.perdeu, bus.vez_jogador, bus.leds, rom[0]);
    end
  endtask

  task automatic test_multibit();
    logic [3:0] v;
    run_cycles(T_ON + T_OFF + show_len(1));
    do v = 4'($urandom); while ($countones(v) < 2);
    press_btn(v);
    n_tests++;
    if (bus.perdeu !== 1'b1 || bus.nivel !== 5'd2 || bus.leds !== rom[0]) begin
      n_fail++;
      $display("FAIL multibit v=%b got p=%b nivel=%0d leds=%b want 1/2/%b",
               v, bus.perdeu, bus.nivel, bus.leds, rom[0]);
    end
  endtask

  task automatic test_held_button();
    start_game();
    run_cycles(show_len(0));
    finish_level(0);
    bus.botao = rom[0];
    tick();
    run_cycles(T_ON);
    n_tests++;
    if (bus.vez_jogador !== 1'b1 || bus.leds !== 4'b0000 || bus.seq_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL held_enter got vez=%b leds=%b addr=%0d want 1/0000/1",
               bus.vez_jogador, bus.leds, bus.seq_addr);
    end
    run_cycles(3);
    n_tests++;
    if (bus.vez_jogador !== 1'b1 || bus.leds !== 4'b0000 || bus.perdeu !== 1'b0) begin
      n_fail++;
      $display("FAIL held_no_press got vez=%b leds=%b p=%b want 1/0000/0",
               bus.vez_jogador, bus.leds, bus.perdeu);
    end
    bus.botao = 4'b0000;
    tick();
    press_btn(rom[1]);
    n_tests++;
    if (bus.leds !== rom[1] || bus.vez_jogador !== 1'b1 || bus.perdeu !== 1'b0) begin
      n_fail++;
      $display("FAIL repress got leds=%b vez=%b p=%b want %b/1/0",
               bus.leds, bus.vez_jogador, bus.perdeu, rom[1]);
    end
  endtask

  task automatic test_full_game();
    rst_n = 1'b0;
    run_cycles(2);
    rst_n = 1'b1;
    for (int i = 3; i < 16; i++) rom[i] = rand_onehot();
    tick();
    start_game();
    run_cycles(show_len(0));
    for (int lvl = 0; lvl <= LAST; lvl++) begin
      n_tests++;
      if (bus.vez_jogador !== 1'b1 || bus.nivel !== 5'(lvl + 1) || bus.leds !== 4'b0000) begin
        n_fail++;
        $display("FAIL game_wait lvl=%0d got vez=%b nivel=%0d leds=%b want 1/%0d/0000",
                 lvl, bus.vez_jogador, bus.nivel, bus.leds, lvl + 1);
      end
      if (lvl < LAST) begin
        finish_level(lvl);
      end else begin
        for (int s = 0; s <= lvl; s++) begin
          press_btn(rom[s]);
          run_cycles(T_ON);
        end
      end
    end
    n_tests++;
    if (bus.ganhou !== 1'b1 || bus.leds !== 4'b1111 || bus.nivel !== 5'd16 ||
        bus.vez_jogador !== 1'b0 || bus.perdeu !== 1'b0) begin
      n_fail++;
      $display("FAIL win got g=%b leds=%b nivel=%0d vez=%b p=%b want 1/1111/16/0/0",
               bus.ganhou, bus.leds, bus.nivel, bus.vez_jogador, bus.perdeu);
    end
    run_cycles(3);
    start_game();
    n_tests++;
    if (bus.ganhou !== 1'b0 || bus.nivel !== 5'd1 || bus.leds !== rom[0]) begin
      n_fail++;
      $display("FAIL win_restart got g=%b nivel=%0d leds=%b want 0/1/%b",
               bus.ganhou, bus.nivel, bus.leds, rom[0]);
    end
  endtask

  task automatic test_reset_mid_echo();
    run_cycles(show_len(0));
    press_btn(rom[0]);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.leds, bus.nivel, bus.vez_jogador, bus.ganhou, bus.perdeu, bus.seq_addr} !== 16'd0)
    begin
      n_fail++;
      $display("FAIL async_reset got leds=%b nivel=%0d vez=%b g=%b p=%b addr=%0d want all 0",
               bus.leds, bus.nivel, bus.vez_jogador, bus.ganhou, bus.perdeu, bus.seq_addr);
    end
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(2);
    n_tests++;
    if (bus.nivel !== 5'd0 || bus.leds !== 4'b0000 || bus.vez_jogador !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got nivel=%0d leds=%b vez=%b want 0/0000/0",
               bus.nivel, bus.leds, bus.vez_jogador);
    end
    start_game();
    n_tests++;
    if (bus.nivel !== 5'd1 || bus.leds !== rom[0]) begin
      n_fail++;
      $display("FAIL post_reset_start got nivel=%0d leds=%b want 1/%b",
               bus.nivel, bus.leds, rom[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = rand_onehot();
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b0001;
    bus.start = 1'b0;
    bus.botao = 4'b0000;
    test_reset();
    test_level0_replay();
    test_level1_replay();
    test_wrong_colour();
    test_ignored_start();
    test_timeout();
    test_multibit();
    test_held_button();
    test_full_game();
    test_reset_mid_echo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
